// File: rtl/bin_to_bcd_if.sv
// Handshake/data bundle between the BCD feeder and its user.
// The master drives load/bin_in; the slave returns status and packed BCD.
interface bin_to_bcd_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) ();
    logic                  load;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic [4*DIGITS-1:0]   data_out;

    modport master (
        output load, bin_in,
        input  busy, done, ovf, data_out
    );

    modport slave (
        input  load, bin_in,
        output busy, done, ovf, data_out
    );
endinterface

// File: rtl/bin_to_bcd_feeder.sv
// Sequential double-dabble binary to packed BCD converter, one bit per clock.
// Optional: define BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module bin_to_bcd_feeder #(
    parameter int          BIN_W      = 27,
    parameter int          DIGITS     = 8,
    parameter logic [3:0]  BLANK_CODE = 4'hF
) (
    input  logic       sclk_1ms,
    input  logic       rst,
    bin_to_bcd_if.slave bus
);
    localparam int OW   = 4 * DIGITS;
    localparam int SR_W = OW + BIN_W;
    localparam int CW   = $clog2(BIN_W + 1);

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) v = v * 64'd10;
        return v;
    endfunction

    localparam logic [63:0] MAXV = pow10(DIGITS) - 64'd1;
    localparam bit OVF_POSSIBLE =
        ((64'd1 << BIN_W) - 64'd1) > MAXV;
    localparam logic [BIN_W-1:0] MAX_BW = MAXV[BIN_W-1:0];

    localparam logic [OW-1:0] NINES = {DIGITS{4'h9}};
    localparam logic [OW-1:0] RST_VAL =
        BLANK_EN ? {{(DIGITS-1){BLANK_CODE}}, 4'h0} : '0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   adj;
    logic [CW-1:0]     cnt;
    logic              ovf_pend;
    logic              ovf_cmp;
    logic [OW-1:0]     bcd;
    logic [OW-1:0]     shown;
    logic              lead;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;
    logic [OW-1:0]     data_q;

    assign ovf_cmp = OVF_POSSIBLE ? (bus.bin_in > MAX_BW) : 1'b0;

    // Add-3 on every BCD nibble >= 5 ahead of the shift
    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[BIN_W+4*i +: 4] >= 4'd5)
                adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
        end
    end

    // Leading-zero blanking walks down from the top digit, digit 0 kept
    always_comb begin
        bcd   = sr[SR_W-1 -: OW];
        shown = bcd;
        lead  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (bcd[4*i +: 4] == 4'd0)) begin
                if (BLANK_EN) shown[4*i +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge sclk_1ms or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= RST_VAL;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.load) begin
                        sr       <= {{OW{1'b0}}, bus.bin_in};
                        ovf_pend <= ovf_cmp;
                        cnt      <= CW'(BIN_W);
                        state    <= SHIFT;
                        busy_q   <= 1'b1;
                    end else begin
                        busy_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    sr  <= adj << 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= DONE;
                end
                DONE: begin
                    data_q <= ovf_pend ? NINES : shown;
                    ovf_q  <= ovf_pend;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.data_out = data_q;

endmodule

// File: tb/tb_bin_to_bcd_feeder.sv
// Directed bench for bin_to_bcd_feeder: latency, overflow, ignored loads,
// async reset, back-to-back starts and optional leading-zero blanking.
module tb_bin_to_bcd_feeder;
    logic sclk_1ms;
    logic rst;
    int   checks;
    int   errors;

    bin_to_bcd_if #(.BIN_W(27), .DIGITS(8)) bus ();

    bin_to_bcd_feeder #(
        .BIN_W(27),
        .DIGITS(8),
        .BLANK_CODE(4'hF)
    ) dut (
        .sclk_1ms(sclk_1ms),
        .rst(rst),
        .bus(bus)
    );

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] EXP_RST = 32'hFFFFFFF0;
    localparam logic [31:0] EXP_42  = 32'hFFFFFF42;
    localparam logic [31:0] EXP_7   = 32'hFFFFFFF7;
    localparam logic [31:0] EXP_0   = 32'hFFFFFFF0;
    localparam logic [31:0] EXP_1   = 32'hFFFFFFF1;
`else
    localparam logic [31:0] EXP_RST = 32'h00000000;
    localparam logic [31:0] EXP_42  = 32'h00000042;
    localparam logic [31:0] EXP_7   = 32'h00000007;
    localparam logic [31:0] EXP_0   = 32'h00000000;
    localparam logic [31:0] EXP_1   = 32'h00000001;
`endif

    initial begin
        sclk_1ms = 1'b0;
        forever #5 sclk_1ms = ~sclk_1ms;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sclk_1ms);
        #1;
    endtask

    task automatic start(input logic [26:0] v);
        bus.load   = 1'b1;
        bus.bin_in = v;
        step();
        bus.load   = 1'b0;
        bus.bin_in = '1;
        chk("busy_after_load", {31'd0, bus.busy}, 32'd1);
        chk("done_after_load", {31'd0, bus.done}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input logic [31:0] exp,
                             input logic eovf, input logic [31:0] prev,
                             input bit inj);
        int bad_hold;
        int bad_busy;
        int bad_done;
        bad_hold = 0;
        bad_busy = 0;
        bad_done = 0;
        for (int k = 1; k <= 27; k++) begin
            bus.load = inj && (k == 5);
            if (bus.load) bus.bin_in = 27'd555;
            step();
            bus.load = 1'b0;
            if (bus.data_out !== prev) bad_hold++;
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.done !== 1'b0) bad_done++;
        end
        chk({tag, "_hold"}, bad_hold, 0);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_early_done"}, bad_done, 0);
        bus.load = inj;
        if (inj) bus.bin_in = 27'd555;
        step();
        bus.load = 1'b0;
        chk({tag, "_done28"}, {31'd0, bus.done}, 32'd1);
        chk({tag, "_busy28"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_data"}, bus.data_out, exp);
        chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eovf});
    endtask

    task automatic post(input string tag, input logic [31:0] exp);
        int bad;
        bad = 0;
        step();
        chk({tag, "_busy29"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done29"}, {31'd0, bus.done}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
            if (bus.data_out !== exp) bad++;
        end
        chk({tag, "_idle_hold"}, bad, 0);
    endtask

    initial begin
        int bad;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.bin_in = '0;
        #12;
        chk("rst_data", bus.data_out, EXP_RST);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        rst = 1'b0;
        step();

        start(27'd12345678);
        wait_done("c12345678", 32'h12345678, 1'b0, EXP_RST, 1'b1);
        post("c12345678", 32'h12345678);

        start(27'd99999999);
        wait_done("c99999999", 32'h99999999, 1'b0, 32'h12345678, 1'b0);
        post("c99999999", 32'h99999999);

        start(27'd100000000);
        wait_done("c1e8", 32'h99999999, 1'b1, 32'h99999999, 1'b0);
        post("c1e8", 32'h99999999);

        start(27'd42);
        repeat (9) step();
        @(posedge sclk_1ms);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_ovf", {31'd0, bus.ovf}, 32'd0);
        chk("arst_data", bus.data_out, EXP_RST);
        @(negedge sclk_1ms);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("arst_no_done", bad, 0);

        start(27'd42);
        wait_done("c42", EXP_42, 1'b0, EXP_RST, 1'b0);
        post("c42", EXP_42);

        start(27'd7);
        wait_done("c7", EXP_7, 1'b0, EXP_42, 1'b0);
        post("c7", EXP_7);

        start(27'd0);
        wait_done("b2b0", EXP_0, 1'b0, EXP_7, 1'b0);
        start(27'd1);
        wait_done("b2b1", EXP_1, 1'b0, EXP_0, 1'b0);
        post("b2b1", EXP_1);

`ifdef BCD_LEADING_ZERO_BLANK_EN
        start(27'd305);
        wait_done("bl305", 32'hFFFFF305, 1'b0, EXP_1, 1'b0);
        post("bl305", 32'hFFFFF305);
        start(27'd0);
        wait_done("bl0", 32'hFFFFFFF0, 1'b0, 32'hFFFFF305, 1'b0);
        post("bl0", 32'hFFFFFFF0);
        start(27'd10000000);
        wait_done("bl1e7", 32'h10000000, 1'b0, 32'hFFFFFFF0, 1'b0);
        post("bl1e7", 32'h10000000);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
